// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: turns per-latch set/clear requests into timed, mutually
// exclusive S/R pulses on a bank of SR latches, serving one latch at a time
// in round-robin order, with guard cycles between pulses.
// Optional Q readback check after each pulse: define SR_CTRL_VERIFY_EN.
module sr_latch_ctrl #(
  parameter int N_LATCH = 4,
  parameter int IDX_W   = 2,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LATCH-1:0] set_req,
  input  logic [N_LATCH-1:0] clr_req,
  input  logic [N_LATCH-1:0] q_fb,
  output logic [N_LATCH-1:0] s_out,
  output logic [N_LATCH-1:0] r_out,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   done_idx,
  output logic               err,
  output logic               conflict
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
`ifdef SR_CTRL_VERIFY_EN
  localparam logic [1:0] ST_CHECK = 2'd3;
`endif

  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]         state_q, state_d;
  logic [N_LATCH-1:0] pend_s_q, pend_s_d;
  logic [N_LATCH-1:0] pend_r_q, pend_r_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_LATCH-1:0] s_out_q, s_out_d;
  logic [N_LATCH-1:0] r_out_q, r_out_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   done_idx_q, done_idx_d;
  logic               conflict_q, conflict_d;
`ifdef SR_CTRL_VERIFY_EN
  logic               op_q, op_d;       // 1 = set operation, 0 = clear
  logic               err_q, err_d;
`endif

  logic [N_LATCH-1:0] pend_any;
  logic [N_LATCH-1:0] svc_clr;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_fire;

  assign pend_any   = pend_s_q | pend_r_q;
  assign grant_fire = (state_q == ST_IDLE) && grant_valid;

  // Round-robin pick: first pending latch after rr_ptr, wrapping around
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    // Scan farthest-first so the nearest pending index is the last to win
    for (int k = N_LATCH; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % N_LATCH);
      if (pend_any[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Per-latch pending capture: clear beats set, a new request overrides
  // an older one, and a request landing on the grant edge survives it
  for (genvar gi = 0; gi < N_LATCH; gi++) begin : g_pend
    assign svc_clr[gi]  = grant_fire && (grant_idx == IDX_W'(gi));
    assign pend_r_d[gi] = clr_req[gi] |
                          (~set_req[gi] & pend_r_q[gi] & ~svc_clr[gi]);
    assign pend_s_d[gi] = ~clr_req[gi] &
                          (set_req[gi] | (pend_s_q[gi] & ~svc_clr[gi]));
  end

  // Sequencer next-state: grant, pulse, guard gap, optional readback
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    s_out_d    = s_out_q;
    r_out_d    = r_out_q;
    done_d     = 1'b0;
    done_idx_d = done_idx_q;
    conflict_d = |(set_req & clr_req);
`ifdef SR_CTRL_VERIFY_EN
    op_d       = op_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        s_out_d = '0;
        r_out_d = '0;
        if (grant_valid) begin
          idx_d    = grant_idx;
          rr_ptr_d = grant_idx;
          cnt_d    = CNT_W'(1);
          state_d  = ST_PULSE;
`ifdef SR_CTRL_VERIFY_EN
          op_d     = pend_s_q[grant_idx];
`endif
          if (pend_s_q[grant_idx]) s_out_d = N_LATCH'(1) << grant_idx;
          else                     r_out_d = N_LATCH'(1) << grant_idx;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_W)) begin
          s_out_d = '0;
          r_out_d = '0;
          cnt_d   = CNT_W'(1);
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        s_out_d = '0;
        r_out_d = '0;
        if (cnt_q == CNT_W'(GAP_W)) begin
`ifdef SR_CTRL_VERIFY_EN
          state_d    = ST_CHECK;
`else
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          done_idx_d = idx_q;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SR_CTRL_VERIFY_EN
      ST_CHECK: begin
        s_out_d    = '0;
        r_out_d    = '0;
        done_d     = 1'b1;
        done_idx_d = idx_q;
        err_d      = (q_fb[idx_q] != op_q);
        state_d    = ST_IDLE;
      end
`endif
      default: begin
        s_out_d = '0;
        r_out_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops the drives at once and discards all work
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_s_q   <= '0;
      pend_r_q   <= '0;
      rr_ptr_q   <= IDX_W'(N_LATCH - 1);
      idx_q      <= '0;
      cnt_q      <= '0;
      s_out_q    <= '0;
      r_out_q    <= '0;
      done_q     <= 1'b0;
      done_idx_q <= '0;
      conflict_q <= 1'b0;
`ifdef SR_CTRL_VERIFY_EN
      op_q       <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      s_out_q    <= s_out_d;
      r_out_q    <= r_out_d;
      done_q     <= done_d;
      done_idx_q <= done_idx_d;
      conflict_q <= conflict_d;
`ifdef SR_CTRL_VERIFY_EN
      op_q       <= op_d;
      err_q      <= err_d;
`endif
    end
  end

  assign s_out    = s_out_q;
  assign r_out    = r_out_q;
  assign done     = done_q;
  assign done_idx = done_idx_q;
  assign conflict = conflict_q;
  assign busy     = (state_q != ST_IDLE) || (|pend_any);

`ifdef SR_CTRL_VERIFY_EN
  assign err = err_q;
`else
  // Without readback the latch feedback is intentionally ignored
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: scoreboard bench for sr_latch_ctrl. A transaction-level
// model (pending op per latch, round-robin pointer, operation timeline)
// predicts every cycle's drives and each completion; a negedge monitor
// compares them. Adapts to SR_CTRL_VERIFY_EN when it is defined.
module tb_sr_latch_ctrl;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int P    = 2;
  localparam int G    = 1;
  localparam int MAXC = 2048;
`ifdef SR_CTRL_VERIFY_EN
  localparam int VERIFY = 1;
`else
  localparam int VERIFY = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  set_req = '0;
  logic [N-1:0]  clr_req = '0;
  logic [N-1:0]  q_fb = '0;
  logic [N-1:0]  s_out, r_out;
  logic          busy, done, err, conflict;
  logic [IW-1:0] done_idx;

  sr_latch_ctrl #(.N_LATCH(N), .IDX_W(IW), .PULSE_W(P), .GAP_W(G)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
    .s_out(s_out), .r_out(r_out), .busy(busy), .done(done),
    .done_idx(done_idx), .err(err), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and per-cycle expectations
  typedef struct { int idx; int op; int done_e; bit err; } op_t;
  op_t exp_q[$];
  bit [N-1:0] exp_s [MAXC];
  bit [N-1:0] exp_r [MAXC];
  bit         exp_busy [MAXC];
  bit         exp_conf [MAXC];
  bit         exp_done [MAXC];
  bit         exp_err  [MAXC];

  // Reference model: pend[i] 0=none 1=set 2=clear
  int pend [N];
  int rr, cur_done, cur_idx, cur_op, next_ok, n_grant, n_done;
  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    rr = N - 1; cur_done = -1; next_ok = 0;
    for (int t = cyc; t < MAXC; t++) begin
      exp_s[t] = '0; exp_r[t] = '0; exp_busy[t] = 0;
      exp_conf[t] = 0; exp_done[t] = 0; exp_err[t] = 0;
    end
    exp_q.delete();
  endtask

  // Apply one edge worth of inputs and advance the model for that edge
  task automatic step(input logic [N-1:0] s, input logic [N-1:0] c, input logic [N-1:0] q);
    int e, found, j, d;
    bit anyp;
    op_t o;
    e = cyc + 1;
    set_req = s; clr_req = c; q_fb = q;
    if (e == cur_done) begin
      o.idx = cur_idx; o.op = cur_op; o.done_e = e;
      o.err = (VERIFY != 0) && ((((q >> cur_idx) & 4'b1) != 0) != (cur_op == 1));
      exp_err[e] = o.err;
      exp_q.push_back(o);
    end
    if (e >= next_ok) begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        j = (rr + k) % N;
        if (found < 0 && pend[j] != 0) found = j;
      end
      if (found >= 0) begin
        cur_idx = found; cur_op = pend[found];
        pend[found] = 0; rr = found; n_grant++;
        d = e + P + G + VERIFY;
        cur_done = d; next_ok = d + 1;
        for (int t = 0; t < P; t++) begin
          if (cur_op == 1) exp_s[e + t] = exp_s[e + t] | N'(1 << found);
          else             exp_r[e + t] = exp_r[e + t] | N'(1 << found);
        end
        exp_done[d] = 1'b1;
      end
    end
    anyp = 0;
    for (int i = 0; i < N; i++) begin
      if (c[i])      pend[i] = 2;
      else if (s[i]) pend[i] = 1;
      if (pend[i] != 0) anyp = 1;
    end
    exp_conf[e] = |(s & c);
    exp_busy[e] = (e < cur_done) || anyp;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic [N-1:0] q);
    for (int i = 0; i < n; i++) step('0, '0, q);
  endtask

  // Monitor: per-cycle drive/flag checks, and a scoreboard pop on each done
  always @(negedge clk) begin
    int e;
    op_t o;
    e = cyc;
    if (chk_en && e < MAXC) begin
      chk("s_out", 32'(s_out), 32'(exp_s[e]));
      chk("r_out", 32'(r_out), 32'(exp_r[e]));
      chk("busy", 32'(busy), 32'(exp_busy[e]));
      chk("conflict", 32'(conflict), 32'(exp_conf[e]));
      chk("done", 32'(done), 32'(exp_done[e]));
      chk("err", 32'(err), 32'(exp_err[e]));
      chk("s_and_r", 32'(s_out & r_out), 32'd0);
      chk("multi_drive", 32'($countones(s_out | r_out) > 1), 32'd0);
      if (done === 1'b1) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          o = exp_q.pop_front();
          chk("done_idx", 32'(done_idx), 32'(o.idx));
          chk("done_cycle", 32'(e), 32'(o.done_e));
          chk("done_err", 32'(err), 32'(o.err));
          $display("op latch=%0d kind=%s cycle=%0d err=%0b", done_idx,
                   (o.op == 1) ? "set" : "clr", e, err);
        end
      end
    end
  end

  initial begin
    n_grant = 0; n_done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_s_out", 32'(s_out), 32'd0);

    // 1: single set on latch 0, feedback agrees
    step(4'b0001, 4'b0000, 4'b0001);
    idle(10, 4'b0001);
    // 2: mixed sets and a clear on one edge
    step(4'b0110, 4'b1000, 4'b0110);
    idle(20, 4'b0110);
    // 3: set and clear together on latch 2
    step(4'b0100, 4'b0100, 4'b0000);
    idle(10, 4'b0000);
    // 4: clear on latch 1 with stale Q=1, then with Q=0
    step(4'b0000, 4'b0010, 4'b0010);
    idle(10, 4'b0010);
    step(4'b0000, 4'b0010, 4'b0000);
    idle(10, 4'b0000);
    // 6: all latches requesting for 12 edges
    for (int i = 0; i < 12; i++) step(4'b1111, 4'b0000, 4'b1111);
    idle(40, 4'b1111);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] rs, rc, rq;
      rs = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      rc = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      rq = N'($urandom);
      step(rs, rc, rq);
    end
    idle(40, 4'b0000);

    // 5: reset in the second cycle of an s_out[3] pulse, clear[0] pending
    step(4'b1000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0001, 4'b0000);
    chk("pre_reset_s_out", 32'(s_out), 32'(4'b1000));
    chk_en = 1'b0;
    rst = 1'b1;
    set_req = '0; clr_req = '0;
    #1;
    chk("async_reset_s_out", 32'(s_out), 32'd0);
    chk("async_reset_r_out", 32'(r_out), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    idle(12, 4'b0000);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_grant - 1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
